cache_ctrl: RTL and testbench

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_ctrl_pkg.sv | 29 ++
 rtl/cache_ctrl_comparator3bit.sv | 13 +
 rtl/cache_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_cache_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the 2-way set-associative cache controller.
// Holds the default geometry, the FSM state encoding and the way-select
// constants used by cache_ctrl and its tag comparators.
package cache_ctrl_pkg;

  localparam int TAG_W_DEF  = 3;
  localparam int IDX_W_DEF  = 2;
  localparam int DATA_W_DEF = 8;

  localparam int NUM_WAYS = 2;

  localparam logic WAY0 = 1'b0;
  localparam logic WAY1 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  // With two ways the replacement pointer always names the way that was
  // not touched last.
  function automatic logic other_way(input logic way);
    return ~way;
  endfunction

endpackage

// File: rtl/cache_ctrl_comparator3bit.sv
// 3-bit equality comparator used for the per-way tag match.
// Ports:
//   a, b : 3-bit operands
//   eq   : 1 when a == b
module comparator3bit (
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic       eq
);

  assign eq = (a == b);

endmodule

// File: rtl/cache_ctrl.sv
// 2-way set-associative, write-through / no-write-allocate cache controller.
// One request is in flight at a time: IDLE accepts, LOOKUP checks both ways,
// MEM_RD fills on a read miss, MEM_WR writes through, RESP pulses once.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   cpu_valid/ready/we/addr/wdata : CPU request handshake ({tag, index} address)
//   resp_valid/hit/rdata    : one-cycle completion pulse and its results
//   mem_req/we/addr/wdata   : memory request, held until mem_ack
//   mem_ack/rdata           : memory completion, read data valid with ack
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int TAG_W  = TAG_W_DEF,
  parameter int IDX_W  = IDX_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cpu_valid,
  output logic                   cpu_ready,
  input  logic                   cpu_we,
  input  logic [TAG_W+IDX_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  output logic                   resp_valid,
  output logic                   resp_hit,
  output logic [DATA_W-1:0]      resp_rdata,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [TAG_W+IDX_W-1:0] mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic                   mem_ack,
  input  logic [DATA_W-1:0]      mem_rdata
);

  localparam int ADDR_W = TAG_W + IDX_W;
  localparam int SETS   = 1 << IDX_W;

  state_t state_q, state_d;

  // Held low through reset and released by the first clock edge after it,
  // so cpu_ready stays low while rst_n is asserted.
  logic run_q, run_d;

  logic                          we_q, we_d;
  logic [ADDR_W-1:0]             addr_q, addr_d;
  logic [DATA_W-1:0]             wdata_q, wdata_d;
  logic                          hit_q, hit_d;
  logic [DATA_W-1:0]             rdata_q, rdata_d;
  logic [SETS-1:0][NUM_WAYS-1:0] valid_q, valid_d;
  logic [SETS-1:0]               lru_q, lru_d;

  logic              accept;
  logic [IDX_W-1:0]  cpu_idx;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [DATA_W-1:0] way_data [NUM_WAYS];
  logic [NUM_WAYS-1:0] tag_eq;
  logic [NUM_WAYS-1:0] way_hit;
  logic              hit_any;
  logic              hit_way;
  logic              victim_way;
  logic              arr_we;
  logic              arr_way;
  logic [DATA_W-1:0] arr_wdata;

  assign accept  = cpu_valid && cpu_ready;
  assign cpu_idx = cpu_addr[IDX_W-1:0];
  assign idx     = addr_q[IDX_W-1:0];
  assign tag     = addr_q[ADDR_W-1:IDX_W];

  // Per-way tag/data storage. The indexed set is read on the accepting edge
  // so LOOKUP works from registered copies of both ways.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_WAYS; gi++) begin : g_way
      localparam logic WAY_ID = 1'(gi);

      logic [TAG_W-1:0]  tag_mem  [SETS];
      logic [DATA_W-1:0] data_mem [SETS];
      logic [TAG_W-1:0]  rd_tag_q;
      logic [DATA_W-1:0] rd_data_q;

      always_ff @(posedge clk) begin
        if (arr_we && (arr_way == WAY_ID)) begin
          tag_mem[idx]  <= tag;
          data_mem[idx] <= arr_wdata;
        end
        if (accept) begin
          rd_tag_q  <= tag_mem[cpu_idx];
          rd_data_q <= data_mem[cpu_idx];
        end
      end

      assign way_data[gi] = rd_data_q;

      comparator3bit u_cmp (
        .a  (tag),
        .b  (rd_tag_q),
        .eq (tag_eq[gi])
      );

      assign way_hit[gi] = valid_q[idx][gi] & tag_eq[gi];
    end
  endgenerate

  assign hit_any = |way_hit;
  // Way 0 wins if both ways somehow match.
  assign hit_way = way_hit[0] ? WAY0 : WAY1;

  // Fill an empty way first (way 0 before way 1), else the LRU way.
  always_comb begin
    victim_way = lru_q[idx];
    if (!valid_q[idx][0]) begin
      victim_way = WAY0;
    end else if (!valid_q[idx][1]) begin
      victim_way = WAY1;
    end
  end

  // Array write port: write hits update in LOOKUP, read misses fill on ack.
  always_comb begin
    arr_we    = 1'b0;
    arr_way   = WAY0;
    arr_wdata = wdata_q;
    if ((state_q == ST_LOOKUP) && we_q && hit_any) begin
      arr_we  = 1'b1;
      arr_way = hit_way;
    end else if ((state_q == ST_MEM_RD) && mem_ack) begin
      arr_we    = 1'b1;
      arr_way   = victim_way;
      arr_wdata = mem_rdata;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = ST_LOOKUP;
      ST_LOOKUP: begin
        if (we_q)         state_d = ST_MEM_WR;
        else if (hit_any) state_d = ST_RESP;
        else              state_d = ST_MEM_RD;
      end
      ST_MEM_RD: if (mem_ack) state_d = ST_RESP;
      ST_MEM_WR: if (mem_ack) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs: everything is qualified by state so it reads as zero when idle.
  always_comb begin
    cpu_ready  = (state_q == ST_IDLE) && run_q;
    resp_valid = (state_q == ST_RESP);
    resp_hit   = resp_valid && hit_q;
    resp_rdata = resp_valid ? rdata_q : '0;
    mem_req    = (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);
    mem_we     = (state_q == ST_MEM_WR);
    mem_addr   = mem_req ? addr_q : '0;
    mem_wdata  = mem_we ? wdata_q : '0;
  end

  // Request latch, response data, valid and LRU bookkeeping.
  always_comb begin
    run_d   = 1'b1;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hit_d   = hit_q;
    rdata_d = rdata_q;
    valid_d = valid_q;
    lru_d   = lru_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
        end
      end
      ST_LOOKUP: begin
        hit_d   = hit_any;
        rdata_d = (!we_q && hit_any) ? way_data[hit_way] : '0;
        if (hit_any) begin
          lru_d[idx] = other_way(hit_way);
        end
      end
      ST_MEM_RD: begin
        if (mem_ack) begin
          rdata_d                = mem_rdata;
          valid_d[idx][victim_way] = 1'b1;
          lru_d[idx]             = other_way(victim_way);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hit_q   <= 1'b0;
      rdata_q <= '0;
      valid_q <= '0;
      lru_q   <= '0;
    end else begin
      run_q   <= run_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hit_q   <= hit_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      lru_q   <= lru_d;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: a directed vector table, zero-wait and
// reset-during-miss sequences, then random traffic checked against a
// per-set most-recently-used residency model and a flat memory image.
module tb_cache_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cpu_valid;
  logic       cpu_ready;
  logic       cpu_we;
  logic [4:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       resp_valid;
  logic       resp_hit;
  logic [7:0] resp_rdata;
  logic       mem_req;
  logic       mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_ack;
  logic [7:0] mem_rdata;

  int tests;
  int fails;

  logic [7:0] mem_img [32];
  logic       ack_tie;

  // Residency model: per set, up to two tags ordered most-recent first.
  int res_tag [4][2];
  int res_n   [4];

  typedef struct {
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata;
    int         mc;
    logic       hit;
    logic [7:0] rdata;
    int         lat;
    int         mcyc;
  } vec_t;

  vec_t vecs [15];

  cache_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_valid  (cpu_valid),
    .cpu_ready  (cpu_ready),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .resp_valid (resp_valid),
    .resp_hit   (resp_hit),
    .resp_rdata (resp_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void model_reset();
    for (int s = 0; s < 4; s++) res_n[s] = 0;
  endfunction

  function automatic bit model_access(input logic we, input logic [4:0] a);
    int s;
    int t;
    s = int'(a[1:0]);
    t = int'(a[4:2]);
    if (res_n[s] > 0 && res_tag[s][0] == t) return 1'b1;
    if (res_n[s] > 1 && res_tag[s][1] == t) begin
      res_tag[s][1] = res_tag[s][0];
      res_tag[s][0] = t;
      return 1'b1;
    end
    if (!we) begin
      res_tag[s][1] = res_tag[s][0];
      res_tag[s][0] = t;
      if (res_n[s] < 2) res_n[s]++;
    end
    return 1'b0;
  endfunction

  function automatic bit outs_zero();
    return !cpu_ready && !resp_valid && !resp_hit && (resp_rdata == 8'h00) &&
           !mem_req && !mem_we && (mem_addr == 5'h00) && (mem_wdata == 8'h00);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    cpu_valid = 1'b0;
    mem_ack   = 1'b0;
    #1;
    check("reset_outputs_zero", 32'(outs_zero()), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(cpu_ready), 32'd1);
    model_reset();
  endtask

  // Issues one request and plays the memory side, acking in the mc-th
  // cycle of mem_req. Latency counts clock edges after acceptance.
  task automatic run_txn(input logic we, input logic [4:0] a, input logic [7:0] wd, input int mc,
                         output logic got_hit, output logic [7:0] got_rdata, output int got_lat,
                         output int got_mc, output logic got_mwe, output logic [4:0] got_maddr,
                         output logic [7:0] got_mwdata, output logic quiet_ok);
    int guard;
    got_hit    = 1'b0;
    got_rdata  = 8'h00;
    got_lat    = -1;
    got_mc     = 0;
    got_mwe    = 1'b0;
    got_maddr  = 5'h00;
    got_mwdata = 8'h00;
    quiet_ok   = 1'b1;
    guard      = 0;
    @(negedge clk);
    while (!cpu_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    cpu_valid = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = wd;
    @(negedge clk);
    cpu_valid = 1'b0;
    cpu_we    = 1'($urandom);
    cpu_addr  = 5'($urandom);
    cpu_wdata = 8'($urandom);
    for (int c = 1; c <= 40; c++) begin
      mem_ack   = ack_tie;
      mem_rdata = 8'($urandom);
      if (cpu_ready) quiet_ok = 1'b0;
      if (!resp_valid && (resp_hit || resp_rdata != 8'h00)) quiet_ok = 1'b0;
      if (!mem_req && (mem_we || mem_addr != 5'h00 || mem_wdata != 8'h00)) quiet_ok = 1'b0;
      if (mem_req) begin
        got_mc++;
        got_mwe    = mem_we;
        got_maddr  = mem_addr;
        got_mwdata = mem_wdata;
        if (got_mc >= mc) begin
          mem_ack = 1'b1;
          if (mem_we) mem_img[mem_addr] = mem_wdata;
          else        mem_rdata = mem_img[mem_addr];
        end
      end
      if (resp_valid) begin
        got_hit   = resp_hit;
        got_rdata = resp_rdata;
        got_lat   = c;
        break;
      end
      @(negedge clk);
    end
    mem_ack = ack_tie;
  endtask

  task automatic do_txn(input string name, input logic we, input logic [4:0] a, input logic [7:0] wd,
                        input int mc, input logic eh, input logic [7:0] erd, input int elat,
                        input int emc);
    logic       got_hit;
    logic [7:0] got_rdata;
    int         got_lat;
    int         got_mc;
    logic       got_mwe;
    logic [4:0] got_maddr;
    logic [7:0] got_mwdata;
    logic       quiet_ok;
    run_txn(we, a, wd, mc, got_hit, got_rdata, got_lat, got_mc, got_mwe, got_maddr, got_mwdata,
            quiet_ok);
    check({name, ".hit"}, 32'(got_hit), 32'(eh));
    check({name, ".rdata"}, 32'(got_rdata), 32'(erd));
    check({name, ".latency"}, 32'(got_lat), 32'(elat));
    check({name, ".mem_cycles"}, 32'(got_mc), 32'(emc));
    if (emc > 0) begin
      check({name, ".mem_we"}, 32'(got_mwe), 32'(we));
      check({name, ".mem_addr"}, 32'(got_maddr), 32'(a));
      if (we) check({name, ".mem_wdata"}, 32'(got_mwdata), 32'(wd));
    end
    check({name, ".idle_outputs_quiet"}, 32'(quiet_ok), 32'd1);
    $display("[TB] %s we=%0d addr=0x%02h wdata=0x%02h -> hit=%0d rdata=0x%02h lat=%0d memcyc=%0d",
             name, we, a, wd, got_hit, got_rdata, got_lat, got_mc);
  endtask

  initial begin
    rst_n     = 1'b1;
    cpu_valid = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 5'h00;
    cpu_wdata = 8'h00;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    ack_tie   = 1'b0;
    tests     = 0;
    fails     = 0;
    for (int i = 0; i < 32; i++) mem_img[i] = 8'($urandom);
    mem_img[5'h01] = 8'h11;
    mem_img[5'h05] = 8'hA5;
    mem_img[5'h09] = 8'h99;
    mem_img[5'h1E] = 8'hE1;
    mem_img[5'h12] = 8'h42;
    mem_img[5'h0D] = 8'hD0;

    //            we    addr   wdata  mc  hit   rdata  lat mcyc
    vecs[0]  = '{1'b0, 5'h05, 8'h00, 3, 1'b0, 8'hA5, 5, 3};  // cold miss, 3-cycle memory
    vecs[1]  = '{1'b0, 5'h05, 8'h00, 1, 1'b1, 8'hA5, 2, 0};  // repeat read hits
    vecs[2]  = '{1'b0, 5'h01, 8'h00, 1, 1'b0, 8'h11, 3, 1};  // fill second way of set 1
    vecs[3]  = '{1'b0, 5'h01, 8'h00, 1, 1'b1, 8'h11, 2, 0};
    vecs[4]  = '{1'b0, 5'h09, 8'h00, 2, 1'b0, 8'h99, 4, 2};  // evicts tag 1
    vecs[5]  = '{1'b0, 5'h01, 8'h00, 1, 1'b1, 8'h11, 2, 0};
    vecs[6]  = '{1'b0, 5'h05, 8'h00, 1, 1'b0, 8'hA5, 3, 1};  // tag 1 was evicted
    vecs[7]  = '{1'b1, 5'h05, 8'h3C, 2, 1'b1, 8'h00, 4, 2};  // write hit
    vecs[8]  = '{1'b0, 5'h05, 8'h00, 1, 1'b1, 8'h3C, 2, 0};  // sees written data
    vecs[9]  = '{1'b1, 5'h01, 8'h5A, 1, 1'b1, 8'h00, 3, 1};  // write hit makes tag 0 MRU
    vecs[10] = '{1'b0, 5'h09, 8'h00, 2, 1'b0, 8'h99, 4, 2};  // so tag 1 is evicted
    vecs[11] = '{1'b0, 5'h01, 8'h00, 1, 1'b1, 8'h5A, 2, 0};
    vecs[12] = '{1'b0, 5'h05, 8'h00, 1, 1'b0, 8'h3C, 3, 1};
    vecs[13] = '{1'b1, 5'h1E, 8'h77, 1, 1'b0, 8'h00, 3, 1};  // write miss, no allocate
    vecs[14] = '{1'b0, 5'h1E, 8'h00, 1, 1'b0, 8'h77, 3, 1};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mc,
             vecs[i].hit, vecs[i].rdata, vecs[i].lat, vecs[i].mcyc);
    end

    // Zero-wait memory: ack tied high, including while idle.
    do_reset();
    ack_tie = 1'b1;
    mem_ack = 1'b1;
    repeat (4) @(negedge clk);
    check("stray_ack_idle", 32'({cpu_ready, resp_valid, mem_req}), 32'b100);
    do_txn("zw_miss", 1'b0, 5'h12, 8'h00, 1, 1'b0, 8'h42, 3, 1);
    do_txn("zw_hit", 1'b0, 5'h12, 8'h00, 1, 1'b1, 8'h42, 2, 0);
    ack_tie = 1'b0;
    mem_ack = 1'b0;

    // Reset while a read miss waits on memory.
    begin : mid_reset
      bit seen;
      bit quiet;
      seen = 1'b0;
      @(negedge clk);
      cpu_valid = 1'b1;
      cpu_we    = 1'b0;
      cpu_addr  = 5'h0D;
      @(negedge clk);
      cpu_valid = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        if (mem_req) seen = 1'b1;
        else @(negedge clk);
      end
      check("midrst_mem_req_seen", 32'(seen), 32'd1);
      #2;
      rst_n     = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 8'hEE;
      #1;
      check("midrst_outputs_zero", 32'(outs_zero()), 32'd1);
      quiet = 1'b1;
      repeat (3) begin
        @(posedge clk);
        #1;
        if (!outs_zero()) quiet = 1'b0;
      end
      check("midrst_quiet_in_reset", 32'(quiet), 32'd1);
      @(negedge clk);
      rst_n   = 1'b1;
      mem_ack = 1'b0;
      @(negedge clk);
      check("midrst_ready_after_release", 32'(cpu_ready), 32'd1);
      model_reset();
    end
    do_txn("midrst_reread", 1'b0, 5'h0D, 8'h00, 2, 1'b0, 8'hD0, 4, 2);

    // Random traffic against the residency model.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      logic       we;
      logic [4:0] a;
      logic [7:0] wd;
      logic [7:0] erd;
      int         mc;
      bit         h;
      we  = ($urandom_range(0, 3) == 0);
      a   = 5'($urandom);
      wd  = 8'($urandom);
      mc  = int'($urandom_range(1, 3));
      erd = we ? 8'h00 : mem_img[a];
      h   = model_access(we, a);
      do_txn($sformatf("rand%0d", n), we, a, wd, mc, h, erd,
             (h && !we) ? 2 : mc + 2, (h && !we) ? 0 : mc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
